// File: rtl/prbs_gen_chk_if.sv
// rtl/prbs_gen_chk_if.sv - generator/checker signal bundle; inv exists only when PRBS_INVERT_EN is defined
interface prbs_gen_chk_if #(
    parameter int DATA_W    = 1,
    parameter int ERR_CNT_W = 16
);
    logic [2:0]           mode_sel;
    logic                 gen_en;
    logic                 err_inj;
    logic [DATA_W-1:0]    gen_out;
    logic                 gen_valid;
    logic [DATA_W-1:0]    chk_in;
    logic                 chk_valid;
    logic                 err_clr;
    logic                 chk_locked;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef PRBS_INVERT_EN
    logic                 inv;
`endif

    modport master (
`ifdef PRBS_INVERT_EN
        output inv,
`endif
        output mode_sel, gen_en, err_inj, chk_in, chk_valid, err_clr,
        input  gen_out, gen_valid, chk_locked, err_count
    );

    modport slave (
`ifdef PRBS_INVERT_EN
        input  inv,
`endif
        input  mode_sel, gen_en, err_inj, chk_in, chk_valid, err_clr,
        output gen_out, gen_valid, chk_locked, err_count
    );
endinterface

// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - PRBS7/9/15/23/31 parallel generator and self-synchronising checker
// PRBS_INVERT_EN adds the inv input for inverted streams on both generator and checker.
module prbs_gen_chk #(
    parameter int DATA_W    = 1,
    parameter int ERR_CNT_W = 16,
    parameter int LOSS_THR  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    prbs_gen_chk_if.slave bus
);
    typedef enum logic {HUNT, LOCKED} chk_state_e;
    localparam int SUM_W = ERR_CNT_W + 1;

    function automatic logic [4:0] poly_n(input logic [2:0] m);
        case (m)
            3'd0:    poly_n = 5'd7;
            3'd1:    poly_n = 5'd9;
            3'd2:    poly_n = 5'd15;
            3'd3:    poly_n = 5'd23;
            default: poly_n = 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] poly_t(input logic [2:0] m);
        case (m)
            3'd0:    poly_t = 5'd6;
            3'd1:    poly_t = 5'd5;
            3'd2:    poly_t = 5'd14;
            3'd3:    poly_t = 5'd18;
            default: poly_t = 5'd28;
        endcase
    endfunction

    function automatic logic [30:0] poly_mask(input logic [4:0] n);
        poly_mask = 31'h7fff_ffff >> (5'd31 - n);
    endfunction

    // One Fibonacci step; the new bit lands in s[0] and is the next output bit.
    function automatic logic [30:0] lfsr_step(input logic [30:0] s, input logic [2:0] m);
        logic fb;
        fb = s[poly_n(m) - 5'd1] ^ s[poly_t(m) - 5'd1];
        lfsr_step = {s[29:0], fb} & poly_mask(poly_n(m));
    endfunction

    logic [2:0]           mode_q, mode_d;
    logic [30:0]          gen_s_q, gen_s_d;
    logic [DATA_W-1:0]    gen_out_q, gen_out_d;
    logic                 gen_valid_q, gen_valid_d;
    logic [30:0]          chk_s_q, chk_s_d;
    logic [5:0]           bit_cnt_q, bit_cnt_d;
    chk_state_e           state_q, state_d;
    logic [3:0]           bad_q, bad_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 locked_q, locked_d;

    logic                 inv_cur, inv_chg;
`ifdef PRBS_INVERT_EN
    logic                 inv_q, inv_d;
    assign inv_d   = bus.inv;
    assign inv_cur = inv_q;
    assign inv_chg = (bus.inv != inv_q);
`else
    assign inv_cur = 1'b0;
    assign inv_chg = 1'b0;
`endif

    logic                 mode_chg;
    logic [30:0]          mask_cur, gs, cs;
    logic [DATA_W-1:0]    gen_word, pred, rx, mism;
    logic [3:0]           pop;
    logic [SUM_W-1:0]     sum;
    logic [5:0]           cnt_sum;

    always_comb begin
        mode_d      = bus.mode_sel;
        gen_s_d     = gen_s_q;
        gen_out_d   = gen_out_q;
        gen_valid_d = 1'b0;
        chk_s_d     = chk_s_q;
        bit_cnt_d   = bit_cnt_q;
        state_d     = state_q;
        bad_d       = bad_q;
        err_cnt_d   = err_cnt_q;
        locked_d    = (state_q == LOCKED);
        mode_chg    = (bus.mode_sel != mode_q) || inv_chg;
        mask_cur    = poly_mask(poly_n(mode_q));
        gs          = gen_s_q;
        cs          = chk_s_q;
        gen_word    = '0;
        pred        = '0;
        rx          = bus.chk_in ^ {DATA_W{inv_cur}};
        mism        = '0;
        pop         = '0;
        sum         = '0;
        cnt_sum     = bit_cnt_q + 6'(DATA_W);

        if (mode_chg) begin
            gen_s_d   = mask_cur | poly_mask(poly_n(bus.mode_sel));
            gen_s_d   = poly_mask(poly_n(bus.mode_sel));
            state_d   = HUNT;
            bit_cnt_d = '0;
            bad_d     = '0;
        end else begin
            if (bus.gen_en) begin
                for (int i = 0; i < DATA_W; i++) begin
                    gs          = lfsr_step(gs, mode_q);
                    gen_word[i] = gs[0];
                end
                gen_s_d     = gs;
                gen_word[0] = gen_word[0] ^ bus.err_inj;
                gen_out_d   = gen_word ^ {DATA_W{inv_cur}};
                gen_valid_d = 1'b1;
            end
            if (bus.chk_valid) begin
                if (state_q == HUNT) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        cs = {cs[29:0], rx[i]} & mask_cur;
                    end
                    chk_s_d   = cs;
                    bit_cnt_d = cnt_sum;
                    if (cnt_sum >= {1'b0, poly_n(mode_q)}) begin
                        bit_cnt_d = '0;
                        if (cs != '0) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end
                end else begin
                    // Advance on predicted bits so one flipped bit costs exactly one count.
                    for (int i = 0; i < DATA_W; i++) begin
                        cs      = lfsr_step(cs, mode_q);
                        pred[i] = cs[0];
                    end
                    chk_s_d = cs;
                    mism    = pred ^ rx;
                    for (int i = 0; i < DATA_W; i++) begin
                        pop = pop + {3'b000, mism[i]};
                    end
                    sum       = {1'b0, err_cnt_q} + SUM_W'(pop);
                    err_cnt_d = sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
                    if (mism != '0) begin
                        if (bad_q + 4'd1 >= 4'(LOSS_THR)) begin
                            state_d   = HUNT;
                            bit_cnt_d = '0;
                            bad_d     = '0;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            end
        end

        if (bus.err_clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= bus.mode_sel;
            gen_s_q     <= poly_mask(poly_n(bus.mode_sel));
            gen_out_q   <= '0;
            gen_valid_q <= 1'b0;
            chk_s_q     <= '0;
            bit_cnt_q   <= '0;
            state_q     <= HUNT;
            bad_q       <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            gen_s_q     <= gen_s_d;
            gen_out_q   <= gen_out_d;
            gen_valid_q <= gen_valid_d;
            chk_s_q     <= chk_s_d;
            bit_cnt_q   <= bit_cnt_d;
            state_q     <= state_d;
            bad_q       <= bad_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
        end
    end

`ifdef PRBS_INVERT_EN
    always_ff @(posedge clk) begin
        inv_q <= inv_d;
    end
`endif

    assign bus.gen_out    = gen_out_q;
    assign bus.gen_valid  = gen_valid_q;
    assign bus.chk_locked = locked_q;
    assign bus.err_count  = err_cnt_q;
endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - directed bench for prbs_gen_chk (DATA_W=8, ERR_CNT_W=4, LOSS_THR=4)
module tb_prbs_gen_chk;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cmode;

    prbs_gen_chk_if #(.DATA_W(8), .ERR_CNT_W(4)) bus ();

    prbs_gen_chk #(.DATA_W(8), .ERR_CNT_W(4), .LOSS_THR(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback with optional corruption: 0 true, 1 bit0 flipped, 2 all zeros.
    task automatic drive_chk();
        case (cmode)
            0:       bus.chk_in = bus.gen_out;
            1:       bus.chk_in = bus.gen_out ^ 8'h01;
            default: bus.chk_in = 8'h00;
        endcase
        bus.chk_valid = bus.gen_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_chk();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmode  = 0;
        rst_n  = 1'b0;
        bus.mode_sel  = 3'd0;
        bus.gen_en    = 1'b0;
        bus.err_inj   = 1'b0;
        bus.chk_in    = 8'h00;
        bus.chk_valid = 1'b0;
        bus.err_clr   = 1'b0;
`ifdef PRBS_INVERT_EN
        bus.inv       = 1'b0;
`endif
        tick();
        tick();
        check("rst_gen_out", bus.gen_out, 0);
        check("rst_gen_valid", bus.gen_valid, 0);
        check("rst_locked", bus.chk_locked, 0);
        check("rst_err_count", bus.err_count, 0);

        // PRBS7 from all ones: bits 0,0,0,0,0,0,1,0 | 0,0,0,0,1,1,0,0 | 0,0,1,0,1,0,0,0
        rst_n = 1'b1;
        bus.gen_en = 1'b1;
        tick();
        check("p7_valid_rise", bus.gen_valid, 1);
        check("p7_word0", bus.gen_out, 8'h40);
        tick();
        check("p7_word1", bus.gen_out, 8'h30);
        bus.gen_en  = 1'b0;
        bus.err_inj = 1'b1;
        tick();
        check("hold_valid", bus.gen_valid, 0);
        check("hold_gen_out", bus.gen_out, 8'h30);
        bus.err_inj = 1'b0;
        bus.gen_en  = 1'b1;
        tick();
        check("p7_word2", bus.gen_out, 8'h14);
        repeat (125) tick();
        check("p7_period_w127", bus.gen_out, 8'h40);
        tick();
        check("p7_period_w128", bus.gen_out, 8'h30);
        check("p7_locked", bus.chk_locked, 1);
        check("p7_err_count", bus.err_count, 0);

        // PRBS31: lock after 4 words plus one cycle
        bus.mode_sel = 3'd4;
        tick();
        check("p31_chg_valid", bus.gen_valid, 0);
        tick();
        check("p31_word0", bus.gen_out, 8'h00);
        check("p31_unlocked", bus.chk_locked, 0);
        repeat (4) tick();
        check("p31_not_yet", bus.chk_locked, 0);
        tick();
        check("p31_locked", bus.chk_locked, 1);
        repeat (10000) tick();
        check("p31_long_err", bus.err_count, 0);
        check("p31_long_lock", bus.chk_locked, 1);

        // PRBS15: injected errors, then err_clr racing an increment
        bus.mode_sel = 3'd2;
        repeat (10) tick();
        check("p15_locked", bus.chk_locked, 1);
        for (int i = 0; i < 3; i++) begin
            bus.err_inj = 1'b1;
            tick();
            bus.err_inj = 1'b0;
            tick();
            tick();
        end
        check("inj3_count", bus.err_count, 3);
        check("inj3_locked", bus.chk_locked, 1);
        bus.err_inj = 1'b1;
        tick();
        bus.err_inj = 1'b0;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clr_wins", bus.err_count, 0);
        tick();
        tick();
        check("clr_dropped", bus.err_count, 0);

        // Four consecutive bad words lose lock; the fourth still counts
        cmode = 1;
        drive_chk();
        repeat (3) tick();
        check("loss_3_locked", bus.chk_locked, 1);
        check("loss_3_count", bus.err_count, 3);
        tick();
        check("loss_4_count", bus.err_count, 4);
        cmode = 0;
        drive_chk();
        tick();
        check("loss_dropped", bus.chk_locked, 0);
        tick();
        check("relock_pending", bus.chk_locked, 0);
        tick();
        check("relock", bus.chk_locked, 1);
        check("relock_count", bus.err_count, 4);

        // All-zero input in HUNT never locks (even word count leaves bit count 0)
        bus.mode_sel = 3'd1;
        cmode = 2;
        drive_chk();
        tick();
        repeat (31) tick();
        check("zeros_unlocked", bus.chk_locked, 0);
        check("zeros_count", bus.err_count, 4);
        cmode = 0;
        drive_chk();
        repeat (6) tick();
        check("p9_locked", bus.chk_locked, 1);
        check("p9_count", bus.err_count, 4);

        // PRBS9 -> PRBS23 mid-stream: reseed to ones, relock after 24 bits
        bus.mode_sel = 3'd3;
        tick();
        tick();
        check("p23_word0", bus.gen_out, 8'h00);
        check("p23_unlocked", bus.chk_locked, 0);
        tick();
        check("p23_word1", bus.gen_out, 8'h00);
        tick();
        check("p23_word2", bus.gen_out, 8'h7c);
        tick();
        check("p23_not_yet", bus.chk_locked, 0);
        tick();
        check("p23_locked", bus.chk_locked, 1);
        check("p23_count", bus.err_count, 4);

        // Saturation of the 4-bit counter
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("sat_cleared", bus.err_count, 0);
        for (int i = 0; i < 20; i++) begin
            bus.err_inj = 1'b1;
            tick();
            bus.err_inj = 1'b0;
            tick();
            tick();
            if (i == 9) check("sat_mid", bus.err_count, 10);
        end
        check("sat_full", bus.err_count, 15);
        check("sat_locked", bus.chk_locked, 1);

        rst_n = 1'b0;
        tick();
        check("rst2_gen_out", bus.gen_out, 0);
        check("rst2_gen_valid", bus.gen_valid, 0);
        check("rst2_locked", bus.chk_locked, 0);
        check("rst2_err_count", bus.err_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
